// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and types for the FIR datapath and its output stage.
//   FIR_DATA_W  : width of a raw FIR accumulator result
//   DISP_DATA_W : width of a display-path sample
//   DROP_CNT_W  : width of the dropped-sample counter
//   sample_t    : signed display-path sample
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DATA_W  = 32;
    localparam int DISP_DATA_W = 16;
    localparam int DROP_CNT_W  = 8;

    typedef logic signed [DISP_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_out_fifo.sv
// -----------------------------------------------------------------------------
// fir_out_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever the FIFO is non-empty; rd_data reads as zero when empty.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr, wr_data: write request; accepted when not full, or when full and a
//                read happens in the same cycle
//   rd         : read request; ignored while empty
//   rd_data    : head entry
//   full, empty: occupancy flags
//   level      : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int W     = DISP_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign level = count;

    // A read frees the slot the write needs, so full-with-read still accepts.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are never visible
    // because rd_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_conv.sv
// -----------------------------------------------------------------------------
// fir_out_conv
// Output conditioning for the 40-tap FIR: captures each result on in_valid,
// keeps one of every DECIM strobes, rounds (half up) and shifts right by
// SHIFT, narrows to OUT_W, and queues results in an FWFT FIFO.
//   in_valid, in_data     : FIR result strobe and data
//   out_valid, out_ready  : FIFO head handshake; out_data is the head entry
//   level                 : FIFO occupancy
//   sat_sticky            : a sample was clamped since the last clr_stat
//   drop_cnt              : samples lost to a full FIFO (saturates at 255)
//   clr_stat              : synchronous clear of sat_sticky and drop_cnt
// Build option: define FIR_OUT_SAT_EN to clamp out-of-range results and
// report them on sat_sticky; otherwise results wrap to OUT_W bits and
// sat_sticky is tied low.
// Latency: strobe sampled at one edge, stage register written, FIFO written
// at the following edge, so out_valid rises two cycles after the strobe.
// -----------------------------------------------------------------------------
module fir_out_conv
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_DATA_W,
    parameter int OUT_W      = DISP_DATA_W,
    parameter int SHIFT      = 16,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          sat_sticky,
    output logic [DROP_CNT_W-1:0]         drop_cnt,
    input  logic                          clr_stat
);

    localparam int              RND_SH    = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0]   RND       = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
    localparam logic [3:0]      DCNT_LAST = 4'(DECIM - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic [3:0]              dcnt;
    logic                    keep;
    logic signed [IN_W:0]    tmp;
    logic [OUT_W-1:0]        narrowed;
    logic                    s1_v;
    logic [OUT_W-1:0]        s1_data;
    logic                    full;
    logic                    empty;
    logic                    drop;

    // Decimation: the strobe that finds dcnt at zero is the one kept.
    assign keep = in_valid && (dcnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= 4'd0;
        end else if (in_valid) begin
            dcnt <= (dcnt == DCNT_LAST) ? 4'd0 : dcnt + 4'd1;
        end
    end

    // One extra bit of headroom so adding the rounding constant cannot overflow.
    assign tmp = $signed({in_data[IN_W-1], in_data}) + $signed(RND);

`ifdef FIR_OUT_SAT_EN
    logic signed [IN_W:0]    r;
    logic [IN_W-OUT_W+1:0]   r_hi;
    logic                    in_range;
    logic                    sat_ev;

    assign r        = tmp >>> SHIFT;
    // In range when every bit above the OUT_W sign bit repeats the sign.
    assign r_hi     = r[IN_W:OUT_W-1];
    assign in_range = (&r_hi) || !(|r_hi);
    assign narrowed = in_range ? r[OUT_W-1:0]
                    : (r[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
    assign sat_ev   = keep && !in_range;

    // A saturation in the same cycle as clr_stat leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sat_sticky <= 1'b0;
        else if (sat_ev)   sat_sticky <= 1'b1;
        else if (clr_stat) sat_sticky <= 1'b0;
    end
`else
    assign narrowed   = OUT_W'(tmp >>> SHIFT);
    assign sat_sticky = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_v    <= keep;
            if (keep) s1_data <= narrowed;
        end
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (s1_v),
        .wr_data (s1_data),
        .rd      (out_ready),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_valid = !empty;

    // Full with a read in the same cycle still accepts the write; only a
    // stalled consumer loses the sample.
    assign drop = s1_v && full && !out_ready;

    // A drop in the same cycle as clr_stat restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_stat)                 drop_cnt <= DROP_CNT_W'(1);
            else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end else if (clr_stat) begin
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fir_out_conv.sv
// -----------------------------------------------------------------------------
// tb_fir_out_conv
// Self-checking bench for fir_out_conv. Two instances: dut (DECIM=1) carries
// the directed and randomized scenarios and is tracked by a transaction-level
// queue model; dut_d4 (DECIM=4) covers decimation.
// -----------------------------------------------------------------------------
module tb_fir_out_conv;
    import fir_pkg::*;

    localparam int SHIFT = 16;
    localparam int DEPTH = 4;
`ifdef FIR_OUT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        clr_stat = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  level;
    logic        sat_sticky;
    logic [7:0]  drop_cnt;

    logic        d4_in_valid = 1'b0;
    logic [31:0] d4_in_data = '0;
    logic        d4_out_ready = 1'b0;
    logic        d4_clr_stat = 1'b0;
    logic        d4_out_valid;
    logic [15:0] d4_out_data;
    logic [2:0]  d4_level;
    logic        d4_sat_sticky;
    logic [7:0]  d4_drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_out_conv #(.SHIFT(SHIFT), .DECIM(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .sat_sticky(sat_sticky), .drop_cnt(drop_cnt),
        .clr_stat(clr_stat)
    );

    fir_out_conv #(.SHIFT(SHIFT), .DECIM(4), .FIFO_DEPTH(DEPTH)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .level(d4_level), .sat_sticky(d4_sat_sticky), .drop_cnt(d4_drop_cnt),
        .clr_stat(d4_clr_stat)
    );

    // ---------------- reference model ----------------
    // Exact rounded quotient floor((x + 2^(SHIFT-1)) / 2^SHIFT) in 64-bit math.
    function automatic longint model_r(input logic [31:0] d);
        longint v, dv, q;
        v  = longint'($signed(d)) + ((SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0);
        dv = longint'(1) << SHIFT;
        q  = v / dv;
        if (v < 0 && (v % dv) != 0) q = q - 1;
        return q;
    endfunction

    function automatic bit model_oor(input logic [31:0] d);
        longint q;
        q = model_r(d);
        return (q > 32767) || (q < -32768);
    endfunction

    function automatic logic [15:0] model_out(input logic [31:0] d);
        longint q;
        q = model_r(d);
        if (SAT_EN && q > 32767)  return 16'h7FFF;
        if (SAT_EN && q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    logic [15:0] mq[$];
    bit          m_pv;
    logic [15:0] m_pd;
    int          m_drop;
    bit          m_sat;
    bit          m_rd;
    bit          m_dr;
    logic [15:0] m_pop;

    // Queue of accepted samples plus one pending stage slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pv   = 1'b0;
            m_drop = 0;
            m_sat  = 1'b0;
        end else begin
            m_rd = out_ready && (mq.size() > 0);
            m_dr = m_pv && (mq.size() == DEPTH) && !m_rd;
            if (m_rd) m_pop = mq.pop_front();
            if (m_pv && !m_dr) mq.push_back(m_pd);
            if (clr_stat) begin
                m_sat  = 1'b0;
                m_drop = 0;
            end
            if (SAT_EN && in_valid && model_oor(in_data)) m_sat = 1'b1;
            if (m_dr && m_drop < 255) m_drop = m_drop + 1;
            m_pv = in_valid;
            m_pd = model_out(in_data);
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        tests++; if (level !== 3'd0) begin fails++; $display("FAIL rst_level got %0d want 0", level); end
        tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
        tests++; if (sat_sticky !== 1'b0) begin fails++; $display("FAIL rst_sat_sticky got %0b want 0", sat_sticky); end
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL rst_out_data got %h want 0000", out_data); end
        rst_n = 1'b1;
        tick();
        send(32'h0001_8000);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat1_out_valid got %0b want 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lat2_out_valid got %0b want 1", out_valid); end
        tests++; if (out_data !== 16'h0002) begin fails++; $display("FAIL lat2_out_data got %h want 0002", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pop_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_rounding();
        logic [31:0] vin  [3] = '{32'hFFFF_8000, 32'hFFFE_8000, 32'h0000_7FFF};
        logic [15:0] vexp [3] = '{16'h0000, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            send(vin[i]);
            tick();
            tests++; if (out_data !== vexp[i] || out_valid !== 1'b1)
                begin fails++; $display("FAIL round_%0d got %h/%0b want %h/1", i, out_data, out_valid, vexp[i]); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] e_pos = SAT_EN ? 16'h7FFF : 16'h8000;
        logic        e_st  = SAT_EN;
        send(32'h7FFF_8000);
        tick();
        tests++; if (out_data !== e_pos) begin fails++; $display("FAIL sat_pos got %h want %h", out_data, e_pos); end
        tests++; if (sat_sticky !== e_st) begin fails++; $display("FAIL sat_sticky got %0b want %0b", sat_sticky, e_st); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send(32'h8000_0000);
        tick();
        tests++; if (out_data !== 16'h8000) begin fails++; $display("FAIL sat_neg got %h want 8000", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        tests++; if (sat_sticky !== 1'b0) begin fails++; $display("FAIL clr_sat got %0b want 0", sat_sticky); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i) << 16;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL bp_level got %0d want 4", level); end
        tests++; if (drop_cnt !== 8'd2) begin fails++; $display("FAIL bp_drop got %0d want 2", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tests++; if (out_data !== 16'(i) || out_valid !== 1'b1)
                begin fails++; $display("FAIL bp_order_%0d got %h/%0b want %h/1", i, out_data, out_valid, 16'(i)); end
            tick();
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %0b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_read();
        logic [7:0]  base;
        logic [15:0] order [4] = '{16'd11, 16'd12, 16'd13, 16'd20};
        for (int i = 10; i <= 13; i++) send(32'(i) << 16);
        tick();
        base = drop_cnt;
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL fr_fill got %0d want 4", level); end
        send(32'd20 << 16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL fr_level got %0d want 4", level); end
        tests++; if (drop_cnt !== base) begin fails++; $display("FAIL fr_drop got %0d want %0d", drop_cnt, base); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_data !== order[i])
                begin fails++; $display("FAIL fr_order_%0d got %h want %h", i, out_data, order[i]); end
            tick();
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fr_empty got %0b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_decim();
        for (int i = 1; i <= 8; i++) begin
            d4_in_valid = 1'b1;
            d4_in_data  = 32'(i) << 16;
            tick();
        end
        d4_in_valid = 1'b0;
        tick();
        tests++; if (d4_level !== 3'd2) begin fails++; $display("FAIL dec_level got %0d want 2", d4_level); end
        tests++; if (d4_out_data !== 16'd1) begin fails++; $display("FAIL dec_first got %h want 0001", d4_out_data); end
        d4_out_ready = 1'b1; tick();
        tests++; if (d4_out_data !== 16'd5) begin fails++; $display("FAIL dec_second got %h want 0005", d4_out_data); end
        tick();
        tests++; if (d4_out_valid !== 1'b0) begin fails++; $display("FAIL dec_empty got %0b want 0", d4_out_valid); end
        d4_out_ready = 1'b0;
    endtask

    task automatic test_midrun_reset();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) send(32'($urandom_range(0, 32'h3FFF_FFFF)));
        tick();
        tests++; if (level !== 3'd3) begin fails++; $display("FAIL mr_level got %0d want 3", level); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_async got %0b want 0", out_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        d = $urandom;
        send(d);
        tick();
        tests++; if (level !== 3'd1) begin fails++; $display("FAIL mr_new_level got %0d want 1", level); end
        tests++; if (out_data !== model_out(d)) begin fails++; $display("FAIL mr_new_data got %h want %h", out_data, model_out(d)); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
                2:       d = 32'h7FFF_7FFF + 32'($urandom_range(0, 1));
                default: d = 32'h8000_0000 + 32'($urandom_range(0, 32'h0001_0000));
            endcase
            in_valid  = (c < 200) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 3);
            in_data   = d;
            out_ready = (c < 200) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            clr_stat  = ($urandom_range(0, 19) == 0);
            tick();
            tests++; if (level !== 3'(mq.size()))
                begin fails++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, mq.size()); end
            tests++; if (out_valid !== (mq.size() > 0))
                begin fails++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, out_valid, mq.size() > 0); end
            tests++; if (out_data !== ((mq.size() > 0) ? mq[0] : 16'h0000))
                begin fails++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, (mq.size() > 0) ? mq[0] : 16'h0000); end
            tests++; if (drop_cnt !== 8'(m_drop))
                begin fails++; $display("FAIL rnd_drop c=%0d got %0d want %0d", c, drop_cnt, m_drop); end
            tests++; if (sat_sticky !== m_sat)
                begin fails++; $display("FAIL rnd_sat c=%0d got %0b want %0b", c, sat_sticky, m_sat); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_stat  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        test_backpressure();
        test_full_read();
        test_decim();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule
